// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem req/ready handshake, one-entry output register to decode.
// Optional perf counters (perf_fetch_cnt, perf_stall_cnt) are built when FETCH_PERF_EN is defined.
module instr_fetch #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned          PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr_out,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                instr_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pend_tgt, tgt;
  logic                xfer;

  assign tgt       = branch_target & ~PC_WIDTH'(3);
  assign xfer      = imem_req && imem_ready;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (branch_taken && imem_req && !imem_ready) state_nxt = DRAIN;
      DRAIN:   if (imem_ready) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    unique case (state)
      RUN:     imem_req = !(instr_valid && stall);
      DRAIN:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // A redirect with an unaccepted request must keep the old address on the bus,
  // so the new target parks in pend_tgt until the memory takes the stale fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      pend_tgt    <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      pc_out      <= '0;
    end else begin
      unique case (state)
        IDLE: if (branch_taken) pc <= tgt;
        RUN: begin
          if (branch_taken) begin
            instr_valid <= 1'b0;
            if (imem_req && !imem_ready) pend_tgt <= tgt;
            else                         pc       <= tgt;
          end else if (xfer) begin
            instr_out   <= imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + PC_WIDTH'(PC_STEP);
          end else if (!stall) begin
            instr_valid <= 1'b0;
          end
        end
        DRAIN: begin
          instr_valid <= 1'b0;
          if (branch_taken) pend_tgt <= tgt;
          if (imem_ready)   pc <= branch_taken ? tgt : pend_tgt;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (state == RUN && !branch_taken && xfer) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (instr_valid && stall)                  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
